// File: rtl/gc_config_loader.sv
// Configuration loader for the global controller: validates a header/bounds/steps
// word stream into shadow registers and commits them to the initializer outputs at once.
module gc_config_loader #(
  parameter int DIMENSION                = 3,
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int NUM_OF_IC_SIGNALS        = 3
) (
  input  logic                                          gc_clk,
  input  logic                                          reset_n,
  input  logic                                          conf_en,
  input  logic                                          cfg_clear,
  input  logic                                          cfg_valid,
  input  logic [31:0]                                   cfg_data,
  output logic                                          cfg_ready,
  output logic                                          config_done,
  output logic                                          cfg_error,
  output logic [DIMENSION*ITERATION_VARIABLE_WIDTH-1:0] init_ivar,
  output logic [DIMENSION*ITERATION_VARIABLE_WIDTH-1:0] upper_bound,
  output logic [DIMENSION*ITERATION_VARIABLE_WIDTH-1:0] step,
  output logic [ITERATION_VARIABLE_WIDTH-1:0]           iteration_interval,
  output logic [NUM_OF_IC_SIGNALS-1:0]                  init_ic,
  output logic                                          restart_mode
);

  localparam int W     = ITERATION_VARIABLE_WIDTH;
  localparam int IDX_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIMENSION - 1);

  typedef enum logic [2:0] {IDLE, HEADER, BOUNDS, STEPS, DONE, ERROR} state_t;

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [W-1:0]                   sh_interval;
  logic [NUM_OF_IC_SIGNALS-1:0]   sh_ic;
  logic                           sh_restart;
  logic [W-1:0]                   sh_lower [DIMENSION];
  logic [W-1:0]                   sh_upper [DIMENSION];
  logic signed [W-1:0]            sh_step  [DIMENSION];

  logic                           accept;
  logic                           header_ok;
  logic [W-1:0]                   f_lower;
  logic [W-1:0]                   f_upper;
  logic [W-1:0]                   f_interval;
  logic signed [W-1:0]            f_step;
  logic                           unused_bits;

  assign cfg_ready  = conf_en & ((state == HEADER) | (state == BOUNDS) | (state == STEPS));
  assign accept     = cfg_valid & cfg_ready;
  assign f_lower    = W'(cfg_data[15:0]);
  assign f_upper    = W'(cfg_data[31:16]);
  assign f_interval = W'(cfg_data[23:8]);
  assign f_step     = W'($signed(cfg_data[15:0]));
  assign header_ok  = (cfg_data[31:24] == 8'hA5) && (cfg_data[23:8] != 16'd0);
  assign unused_bits = ^cfg_data;

  // Dimension 0 sits in the most significant slice of each packed output.
  always_ff @(posedge gc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      idx                <= '0;
      config_done        <= 1'b0;
      cfg_error          <= 1'b0;
      sh_interval        <= '0;
      sh_ic              <= '0;
      sh_restart         <= 1'b0;
      init_ivar          <= '0;
      upper_bound        <= '0;
      step               <= '0;
      iteration_interval <= '0;
      init_ic            <= '0;
      restart_mode       <= 1'b0;
      for (int d = 0; d < DIMENSION; d++) begin
        sh_lower[d] <= '0;
        sh_upper[d] <= '0;
        sh_step[d]  <= '0;
      end
    end else if (cfg_clear) begin
      state       <= conf_en ? HEADER : IDLE;
      idx         <= '0;
      config_done <= 1'b0;
      cfg_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (conf_en) state <= HEADER;
        HEADER, BOUNDS, STEPS: begin
          if (!conf_en) begin
            // Losing enable mid-load abandons the partial stream silently.
            state       <= IDLE;
            idx         <= '0;
            sh_interval <= '0;
            sh_ic       <= '0;
            sh_restart  <= 1'b0;
            for (int d = 0; d < DIMENSION; d++) begin
              sh_lower[d] <= '0;
              sh_upper[d] <= '0;
              sh_step[d]  <= '0;
            end
          end else if (accept) begin
            if (state == HEADER) begin
              if (!header_ok) begin
                state     <= ERROR;
                cfg_error <= 1'b1;
              end else begin
                sh_interval <= f_interval;
                sh_ic       <= cfg_data[4 +: NUM_OF_IC_SIGNALS];
                sh_restart  <= cfg_data[0];
                idx         <= '0;
                state       <= BOUNDS;
              end
            end else if (state == BOUNDS) begin
              sh_lower[idx] <= f_lower;
              sh_upper[idx] <= f_upper;
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= STEPS;
              end else begin
                idx <= idx + 1'b1;
              end
            end else if (cfg_data[15:0] == 16'd0) begin
              state     <= ERROR;
              cfg_error <= 1'b1;
            end else begin
              sh_step[idx] <= f_step;
              if (idx == LAST_IDX) begin
                // Atomic commit; the last step bypasses its shadow slot.
                for (int d = 0; d < DIMENSION; d++) begin
                  init_ivar[(DIMENSION-1-d)*W +: W]   <= sh_lower[d];
                  upper_bound[(DIMENSION-1-d)*W +: W] <= sh_upper[d];
                  step[(DIMENSION-1-d)*W +: W]        <= (d == DIMENSION - 1) ? f_step : sh_step[d];
                end
                iteration_interval <= sh_interval;
                init_ic            <= sh_ic;
                restart_mode       <= sh_restart;
                config_done        <= 1'b1;
                state              <= DONE;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        DONE:    state <= DONE;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_config_loader.sv
// Directed bench for gc_config_loader: nominal, backpressure, error, abort, clear and reset cases.
module tb_gc_config_loader;

  localparam int DIM = 3;
  localparam int W   = 16;
  localparam int NIC = 3;

  logic             gc_clk    = 1'b0;
  logic             reset_n   = 1'b0;
  logic             conf_en   = 1'b0;
  logic             cfg_clear = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [31:0]      cfg_data  = '0;
  logic             cfg_ready;
  logic             config_done;
  logic             cfg_error;
  logic [DIM*W-1:0] init_ivar;
  logic [DIM*W-1:0] upper_bound;
  logic [DIM*W-1:0] step;
  logic [W-1:0]     iteration_interval;
  logic [NIC-1:0]   init_ic;
  logic             restart_mode;

  int checks = 0;
  int errors = 0;

  logic [31:0] nom [7] = '{32'hA500_0471, 32'h000A_0000, 32'h0005_0001, 32'h0003_0000,
                           32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
  logic [31:0] alt [7] = '{32'hA500_0920, 32'h1234_0010, 32'hFFFF_0002, 32'h0007_0003,
                           32'h0000_FFFF, 32'h0000_0004, 32'h0000_8000};
  logic [31:0] zs  [7] = '{32'hA500_0471, 32'h000A_0000, 32'h0005_0001, 32'h0003_0000,
                           32'h0000_0001, 32'h0000_0001, 32'h0000_0000};

  always #5 gc_clk = ~gc_clk;

  gc_config_loader #(
    .DIMENSION(DIM), .ITERATION_VARIABLE_WIDTH(W), .NUM_OF_IC_SIGNALS(NIC)
  ) dut (
    .gc_clk(gc_clk), .reset_n(reset_n), .conf_en(conf_en), .cfg_clear(cfg_clear),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .config_done(config_done), .cfg_error(cfg_error), .init_ivar(init_ivar),
    .upper_bound(upper_bound), .step(step), .iteration_interval(iteration_interval),
    .init_ic(init_ic), .restart_mode(restart_mode)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cfg(input string tag, input logic [47:0] iv, input logic [47:0] ub,
                           input logic [47:0] st, input logic [15:0] ii,
                           input logic [2:0] ic, input logic rm);
    chk({tag, ".init_ivar"}, init_ivar, iv);
    chk({tag, ".upper_bound"}, upper_bound, ub);
    chk({tag, ".step"}, step, st);
    chk({tag, ".interval"}, iteration_interval, ii);
    chk({tag, ".init_ic"}, init_ic, ic);
    chk({tag, ".restart"}, restart_mode, rm);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    cfg_valid = 1'b0;
    repeat (gap) @(negedge gc_clk);
    cfg_data  = w;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge gc_clk);
      n++;
    end
    if (!cfg_ready) begin
      chk("accept_timeout", cfg_ready, 1);
      cfg_valid = 1'b0;
      return;
    end
    @(posedge gc_clk);
    @(negedge gc_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [31:0] s [7], input int cnt);
    for (int i = 0; i < cnt; i++) send_word(s[i], 0);
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    @(negedge gc_clk);
    cfg_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge gc_clk);
    chk("rst.ready", cfg_ready, 0);
    chk("rst.done", config_done, 0);
    chk("rst.error", cfg_error, 0);
    check_cfg("rst", 48'h0, 48'h0, 48'h0, 16'h0, 3'h0, 1'b0);
    reset_n = 1'b1;
    @(negedge gc_clk);
    chk("idle.ready", cfg_ready, 0);
    conf_en = 1'b1;
    #1 chk("idle.ready_same_cycle", cfg_ready, 0);
    @(negedge gc_clk);
    chk("header.ready", cfg_ready, 1);

    // Nominal load
    for (int i = 0; i < 6; i++) send_word(nom[i], 0);
    chk("nom.done_before_last", config_done, 0);
    chk("nom.no_partial", init_ivar, 48'h0);
    send_word(nom[6], 0);
    chk("nom.done", config_done, 1);
    chk("nom.ready_done", cfg_ready, 0);
    chk("nom.error", cfg_error, 0);
    check_cfg("nom", 48'h0000_0001_0000, 48'h000A_0005_0003, 48'h0001_0001_0002,
              16'd4, 3'b111, 1'b1);
    cfg_data = alt[0];
    cfg_valid = 1'b1;
    repeat (2) @(negedge gc_clk);
    cfg_valid = 1'b0;
    chk("done.ignores_words", upper_bound, 48'h000A_0005_0003);
    pulse_clear();
    chk("clear.done", config_done, 0);
    chk("clear.ready", cfg_ready, 1);
    chk("clear.retained", step, 48'h0001_0001_0002);

    // Bad magic, then clear and reload
    send_word(32'h5A00_0471, 0);
    chk("magic.error", cfg_error, 1);
    chk("magic.ready", cfg_ready, 0);
    chk("magic.done", config_done, 0);
    pulse_clear();
    chk("magic_clr.error", cfg_error, 0);
    chk("magic_clr.ready", cfg_ready, 1);
    send_stream(alt, 7);
    chk("alt.done", config_done, 1);
    check_cfg("alt", 48'h0010_0002_0003, 48'h1234_FFFF_0007, 48'hFFFF_0004_8000,
              16'd9, 3'b010, 1'b0);

    // Zero step keeps prior committed values
    pulse_clear();
    send_stream(zs, 7);
    chk("zstep.error", cfg_error, 1);
    chk("zstep.done", config_done, 0);
    check_cfg("zstep_hold", 48'h0010_0002_0003, 48'h1234_FFFF_0007, 48'hFFFF_0004_8000,
              16'd9, 3'b010, 1'b0);

    // Abort by dropping conf_en, then full reload
    pulse_clear();
    send_stream(nom, 3);
    conf_en = 1'b0;
    @(negedge gc_clk);
    chk("abort.ready", cfg_ready, 0);
    chk("abort.error", cfg_error, 0);
    conf_en = 1'b1;
    @(negedge gc_clk);
    chk("abort.ready_again", cfg_ready, 1);
    send_stream(nom, 7);
    chk("abort_reload.done", config_done, 1);
    chk("abort_reload.error", cfg_error, 0);
    check_cfg("abort_reload", 48'h0000_0001_0000, 48'h000A_0005_0003, 48'h0001_0001_0002,
              16'd4, 3'b111, 1'b1);

    // Clear coincident with a word that would be accepted
    pulse_clear();
    cfg_data  = 32'h5A00_0471;
    cfg_valid = 1'b1;
    cfg_clear = 1'b1;
    #1 chk("coinc.ready", cfg_ready, 1);
    @(negedge gc_clk);
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
    chk("coinc.no_error", cfg_error, 0);
    chk("coinc.header", cfg_ready, 1);
    send_stream(alt, 7);
    chk("coinc.done", config_done, 1);
    check_cfg("coinc", 48'h0010_0002_0003, 48'h1234_FFFF_0007, 48'hFFFF_0004_8000,
              16'd9, 3'b010, 1'b0);

    // Asynchronous reset mid-load
    pulse_clear();
    send_stream(alt, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.ready", cfg_ready, 0);
    chk("arst.done", config_done, 0);
    check_cfg("arst", 48'h0, 48'h0, 48'h0, 16'h0, 3'h0, 1'b0);
    @(negedge gc_clk);
    reset_n = 1'b1;
    @(negedge gc_clk);

    // Zero step straight after reset leaves outputs at zero
    send_stream(zs, 7);
    chk("zstep_rst.error", cfg_error, 1);
    check_cfg("zstep_rst", 48'h0, 48'h0, 48'h0, 16'h0, 3'h0, 1'b0);

    // Backpressure: random gaps, outputs untouched until the commit edge
    pulse_clear();
    for (int i = 0; i < 7; i++) begin
      send_word(nom[i], $urandom_range(0, 3));
      if (i < 6) begin
        chk("bp.done_early", config_done, 0);
        chk("bp.ivar_early", init_ivar, 48'h0);
        chk("bp.ub_early", upper_bound, 48'h0);
      end
    end
    chk("bp.done", config_done, 1);
    check_cfg("bp", 48'h0000_0001_0000, 48'h000A_0005_0003, 48'h0001_0001_0002,
              16'd4, 3'b111, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
